// File: rtl/gray_pkg.sv
// gray_pkg
// Shared definitions for Gray-code blocks: the sweep state encoding,
// direction constants and a width-agnostic binary-to-Gray helper.
// Used by bin_to_gray and gray_sweep_ctrl. No ports.
package gray_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } gray_state_e;

  localparam logic DIR_UP   = 1'b0;
  localparam logic DIR_DOWN = 1'b1;

  localparam int GRAY_MAX_WIDTH = 16;

  // Callers zero-extend narrower codes; the upper bits stay zero.
  function automatic logic [GRAY_MAX_WIDTH-1:0] bin2gray(
    input logic [GRAY_MAX_WIDTH-1:0] b
  );
    return b ^ (b >> 1);
  endfunction

endpackage

// File: rtl/bin_to_gray.sv
// bin_to_gray
// Purely combinational binary-to-Gray encoder.
// Ports:
//   bin  - binary input, WIDTH bits
//   gray - Gray encoding of bin, WIDTH bits
module bin_to_gray
  import gray_pkg::*;
#(
  parameter int WIDTH = 3
) (
  input  logic [WIDTH-1:0] bin,
  output logic [WIDTH-1:0] gray
);

  assign gray = WIDTH'(bin2gray(GRAY_MAX_WIDTH'(bin)));

endmodule

// File: rtl/gray_sweep_ctrl.sv
// gray_sweep_ctrl
// Sweeps a binary count through its full 2^WIDTH range, one code per
// accepted transfer, and presents each count with its Gray encoding.
// Optional adjacency checker enabled by defining GRAY_SWEEP_CHECK_EN.
// Ports:
//   clk, rst        - clock, synchronous active-high reset
//   start, dir      - begin a sweep (IDLE only); 0 = up from 0, 1 = down from all-ones
//   abort           - terminate a running sweep, no done pulse
//   code_ready      - consumer accepts the current code
//   code_valid      - bin/gray hold a valid code
//   bin, gray       - current binary count and its Gray encoding
//   last            - current code is the final one of the sweep
//   busy            - not IDLE
//   done            - one-cycle pulse after the final code is accepted
//   err             - sticky adjacency failure (0 when the checker is absent)
//
// state | meaning
// IDLE  | waiting for start, no valid code
// RUN   | presenting codes, advancing on each transfer
// DONE  | one-cycle done pulse, then back to IDLE
module gray_sweep_ctrl
  import gray_pkg::*;
#(
  parameter int WIDTH = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             dir,
  input  logic             abort,
  input  logic             code_ready,
  output logic             code_valid,
  output logic [WIDTH-1:0] bin,
  output logic [WIDTH-1:0] gray,
  output logic             last,
  output logic             busy,
  output logic             done,
  output logic             err
);

  localparam logic [1:0] ST_IDLE = IDLE;
  localparam logic [1:0] ST_RUN  = RUN;
  localparam logic [1:0] ST_DONE = DONE;

  localparam logic [WIDTH-1:0] BIN_MAX = '1;

  logic [1:0]       state;
  logic [WIDTH-1:0] bin_q;
  logic             dir_q;
  logic             xfer;
  logic             end_code;

  assign end_code = (dir_q == DIR_DOWN) ? (bin_q == '0) : (bin_q == BIN_MAX);
  assign xfer     = (state == ST_RUN) && code_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
      bin_q <= '0;
      dir_q <= DIR_UP;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            state <= ST_RUN;
            dir_q <= dir;
            bin_q <= (dir == DIR_DOWN) ? BIN_MAX : '0;
          end
        end
        ST_RUN: begin
          // abort takes priority: a same-cycle transfer is accepted but bin holds
          if (abort) begin
            state <= ST_IDLE;
          end else if (xfer) begin
            if (end_code) begin
              state <= ST_DONE;
            end else if (dir_q == DIR_DOWN) begin
              bin_q <= bin_q - 1'b1;
            end else begin
              bin_q <= bin_q + 1'b1;
            end
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  bin_to_gray #(.WIDTH(WIDTH)) u_b2g (
    .bin  (bin_q),
    .gray (gray)
  );

  assign bin        = bin_q;
  assign code_valid = (state == ST_RUN);
  assign last       = (state == ST_RUN) && end_code;
  assign busy       = (state != ST_IDLE);
  assign done       = (state == ST_DONE);

`ifdef GRAY_SWEEP_CHECK_EN
  logic [WIDTH-1:0] prev_gray;
  logic             have_prev;
  logic             err_q;

  // Compares against the output net so any corruption of gray is visible.
  always_ff @(posedge clk) begin
    if (rst) begin
      prev_gray <= '0;
      have_prev <= 1'b0;
      err_q     <= 1'b0;
    end else if (state != ST_RUN) begin
      have_prev <= 1'b0;
    end else if (xfer) begin
      if (have_prev && ($countones(prev_gray ^ gray) != 1)) begin
        err_q <= 1'b1;
      end
      prev_gray <= gray;
      have_prev <= 1'b1;
    end
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_gray_sweep_ctrl.sv
module tb_gray_sweep_ctrl;

  localparam int WIDTH = 3;

  logic             clk = 1'b0;
  logic             rst, start, dir, abort, code_ready;
  logic             code_valid, last, busy, done, err;
  logic [WIDTH-1:0] bin, gray;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  gray_sweep_ctrl #(.WIDTH(WIDTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .dir        (dir),
    .abort      (abort),
    .code_ready (code_ready),
    .code_valid (code_valid),
    .bin        (bin),
    .gray       (gray),
    .last       (last),
    .busy       (busy),
    .done       (done),
    .err        (err)
  );

  typedef struct {
    logic       rst, start, dir, abort, rdy;
    logic       e_valid;
    logic [2:0] e_bin, e_gray;
    logic       e_last, e_busy, e_done;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic r, st, d, ab, rd,
                     input logic v, input logic [2:0] b, g,
                     input logic l, bu, dn);
    vec_t x;
    x.rst = r; x.start = st; x.dir = d; x.abort = ab; x.rdy = rd;
    x.e_valid = v; x.e_bin = b; x.e_gray = g;
    x.e_last = l; x.e_busy = bu; x.e_done = dn;
    vecs.push_back(x);
  endtask

  task automatic check(input string name, input int idx,
                       input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s step=%0d got=%0h want=%0h", name, idx, act, exp);
    end
  endtask

  task automatic drive(input logic r, st, d, ab, rd);
    rst = r; start = st; dir = d; abort = ab; code_ready = rd;
  endtask

  initial begin
    //  rst st dir ab rdy | valid bin gray  last busy done
    add(0, 1, 0, 0, 1,   0, 3'd0, 3'b000, 0, 0, 0); // reset values, start up
    add(0, 0, 0, 0, 1,   1, 3'd0, 3'b000, 0, 1, 0);
    add(0, 0, 0, 0, 1,   1, 3'd1, 3'b001, 0, 1, 0);
    add(0, 0, 0, 0, 1,   1, 3'd2, 3'b011, 0, 1, 0);
    add(0, 0, 0, 0, 1,   1, 3'd3, 3'b010, 0, 1, 0);
    add(0, 0, 0, 0, 1,   1, 3'd4, 3'b110, 0, 1, 0);
    add(0, 0, 0, 0, 1,   1, 3'd5, 3'b111, 0, 1, 0);
    add(0, 0, 0, 0, 1,   1, 3'd6, 3'b101, 0, 1, 0);
    add(0, 0, 0, 0, 1,   1, 3'd7, 3'b100, 1, 1, 0);
    add(0, 0, 0, 0, 1,   0, 3'd7, 3'b100, 0, 1, 1); // done pulse
    add(0, 1, 1, 0, 1,   0, 3'd7, 3'b100, 0, 0, 0); // idle, start down
    add(0, 0, 0, 0, 1,   1, 3'd7, 3'b100, 0, 1, 0);
    add(0, 1, 0, 0, 1,   1, 3'd6, 3'b101, 0, 1, 0); // start in RUN ignored
    add(0, 0, 0, 0, 1,   1, 3'd5, 3'b111, 0, 1, 0);
    add(0, 0, 0, 0, 1,   1, 3'd4, 3'b110, 0, 1, 0);
    add(0, 0, 0, 0, 1,   1, 3'd3, 3'b010, 0, 1, 0);
    add(0, 0, 0, 0, 1,   1, 3'd2, 3'b011, 0, 1, 0);
    add(0, 0, 0, 0, 1,   1, 3'd1, 3'b001, 0, 1, 0);
    add(0, 0, 0, 0, 1,   1, 3'd0, 3'b000, 1, 1, 0);
    add(0, 1, 0, 0, 1,   0, 3'd0, 3'b000, 0, 1, 1); // start in DONE ignored
    add(0, 1, 0, 0, 1,   0, 3'd0, 3'b000, 0, 0, 0); // back-to-back start
    add(0, 0, 0, 0, 1,   1, 3'd0, 3'b000, 0, 1, 0);
    add(0, 0, 0, 0, 1,   1, 3'd1, 3'b001, 0, 1, 0);
    add(0, 0, 0, 0, 0,   1, 3'd2, 3'b011, 0, 1, 0); // stall 3 cycles
    add(0, 0, 0, 0, 0,   1, 3'd2, 3'b011, 0, 1, 0);
    add(0, 0, 0, 0, 0,   1, 3'd2, 3'b011, 0, 1, 0);
    add(0, 0, 0, 0, 1,   1, 3'd2, 3'b011, 0, 1, 0);
    add(0, 0, 0, 0, 1,   1, 3'd3, 3'b010, 0, 1, 0);
    add(0, 0, 0, 1, 1,   1, 3'd4, 3'b110, 0, 1, 0); // abort with transfer
    add(0, 1, 0, 1, 0,   0, 3'd4, 3'b110, 0, 0, 0); // idle, no done; start wins
    add(0, 0, 0, 0, 1,   1, 3'd0, 3'b000, 0, 1, 0);
    add(0, 0, 0, 0, 1,   1, 3'd1, 3'b001, 0, 1, 0);
    add(1, 0, 0, 0, 1,   1, 3'd2, 3'b011, 0, 1, 0); // reset mid-sweep
    add(0, 0, 0, 1, 1,   0, 3'd0, 3'b000, 0, 0, 0); // abort in IDLE ignored
    add(0, 0, 0, 0, 0,   0, 3'd0, 3'b000, 0, 0, 0);

    drive(1, 0, 0, 0, 0);
    repeat (2) @(posedge clk);

    foreach (vecs[i]) begin
      @(negedge clk);
      drive(vecs[i].rst, vecs[i].start, vecs[i].dir, vecs[i].abort, vecs[i].rdy);
      check("code_valid", i, 32'(code_valid), 32'(vecs[i].e_valid));
      check("bin",        i, 32'(bin),        32'(vecs[i].e_bin));
      check("gray",       i, 32'(gray),       32'(vecs[i].e_gray));
      check("last",       i, 32'(last),       32'(vecs[i].e_last));
      check("busy",       i, 32'(busy),       32'(vecs[i].e_busy));
      check("done",       i, 32'(done),       32'(vecs[i].e_done));
      check("err",        i, 32'(err),        32'h0);
    end

    // Down sweep with irregular ready: every code appears once, in order.
    begin
      logic [2:0] m_bin;
      logic       m_run, fin, rd;
      m_bin = 3'd7; m_run = 1'b1; fin = 1'b0;
      @(negedge clk);
      drive(0, 1, 1, 0, 0);
      @(negedge clk);
      drive(0, 0, 0, 0, 0);
      for (int c = 0; c < 40 && !fin; c++) begin
        rd = ((c % 3) != 0);
        if (m_run) begin
          check("toggle_valid", c, 32'(code_valid), 32'h1);
          check("toggle_bin",   c, 32'(bin),        32'(m_bin));
          check("toggle_gray",  c, 32'(gray),       32'(m_bin ^ (m_bin >> 1)));
          check("toggle_last",  c, 32'(last),       32'(m_bin == 3'd0));
          if (rd) begin
            if (m_bin == 3'd0) m_run = 1'b0;
            else m_bin = m_bin - 3'd1;
          end
        end else begin
          check("toggle_done", c, 32'(done), 32'h1);
          fin = 1'b1;
        end
        code_ready = rd;
        @(negedge clk);
      end
      if (!fin) check("toggle_timeout", 0, 32'h0, 32'h1);
      drive(0, 0, 0, 0, 0);
      @(negedge clk);
      check("toggle_idle", 0, 32'(busy), 32'h0);
    end

`ifdef GRAY_SWEEP_CHECK_EN
    // Corrupt gray on the bin=2 transfer; err must latch and hold until rst.
    drive(0, 1, 0, 0, 1);
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("force_pre_err", 0, 32'(err), 32'h0);
    check("force_at_bin",  0, 32'(bin), 32'h2);
    force dut.gray = 3'b111;
    @(negedge clk);
    release dut.gray;
    @(negedge clk);
    check("force_err_set", 0, 32'(err), 32'h1);
    repeat (8) @(negedge clk);
    check("force_err_held", 0, 32'(err), 32'h1);
    check("force_idle",     0, 32'(busy), 32'h0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("force_err_clr", 0, 32'(err), 32'h0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
